// File: rtl/multicycle_mem.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_mem
//  Brief    : Fixed-latency, word-organised memory responder. Accepts one
//             request at a time while idle, holds ready low for LATENCY
//             cycles, then commits the write or returns the read data with
//             a one-cycle data_valid pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module multicycle_mem #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 4     // legal range 1..15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              ready
);

  localparam int         DEPTH        = 1 << DEPTH_LOG2;
  // The accept edge itself counts as the first latency cycle.
  localparam logic [3:0] C_COUNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  // Storage; deliberately not cleared by reset.
  logic [DATA_W-1:0] mem [DEPTH];

  state_t                state_q,      state_d;
  logic [3:0]            count_q,      count_d;
  logic                  wr_q,         wr_d;
  logic [DEPTH_LOG2-1:0] idx_q,        idx_d;
  logic [DATA_W-1:0]     wdata_q,      wdata_d;
  logic [DATA_W-1:0]     data_out_q,   data_out_d;
  logic                  data_valid_q, data_valid_d;
  logic                  ready_q,      ready_d;

  logic                  w_accept;
  logic                  w_done;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic [DATA_W-1:0]     w_rdata;
  logic                  w_unused_addr;

  // Byte address to word index; bit 0 and the bits above the index alias.
  assign w_idx         = addr[DEPTH_LOG2:1];
  assign w_unused_addr = ^{addr[0], addr[ADDR_W-1:DEPTH_LOG2+1]};

  assign w_accept = (state_q == S_IDLE) && enable;
  assign w_done   = (state_q == S_BUSY) && (count_q == 4'd0);
  assign w_rdata  = mem[idx_q];

  // Next-state logic: latch the request on accept, count down while busy,
  // complete when the counter has reached zero.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    wr_d         = wr_q;
    idx_d        = idx_q;
    wdata_d      = wdata_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    ready_d      = ready_q;

    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          wr_d    = wr;
          idx_d   = w_idx;
          wdata_d = data_in;
          count_d = C_COUNT_INIT;
          state_d = S_BUSY;
          ready_d = 1'b0;
        end
      end
      S_BUSY: begin
        if (w_done) begin
          if (!wr_q) begin
            data_out_d   = w_rdata;
            data_valid_d = 1'b1;
          end
          state_d = S_IDLE;
          ready_d = 1'b1;
        end else begin
          count_d = count_q - 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  // State and registered outputs; reset aborts any request in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      count_q      <= 4'd0;
      wr_q         <= 1'b0;
      idx_q        <= '0;
      wdata_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      wr_q         <= wr_d;
      idx_q        <= idx_d;
      wdata_q      <= wdata_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      ready_q      <= ready_d;
    end
  end

  // Write commit at the completion edge, suppressed by a coincident reset.
  always_ff @(posedge clk) begin
    if (!rst && w_done && wr_q) begin
      mem[idx_q] <= wdata_q;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign ready      = ready_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_mem.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multicycle_mem
//  Brief    : Scoreboard bench for multicycle_mem, LATENCY=4 and LATENCY=1.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_mem;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // LATENCY=4 instance
  logic        en4 = 1'b0, wr4 = 1'b0;
  logic [15:0] addr4 = '0, din4 = '0;
  logic [15:0] dout4;
  logic        dv4, rdy4;

  // LATENCY=1 instance
  logic        en1 = 1'b0, wr1 = 1'b0;
  logic [15:0] addr1 = '0, din1 = '0;
  logic [15:0] dout1;
  logic        dv1, rdy1;

  multicycle_mem #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(10), .LATENCY(4)) dut (
    .clk(clk), .rst(rst), .enable(en4), .wr(wr4), .addr(addr4), .data_in(din4),
    .data_out(dout4), .data_valid(dv4), .ready(rdy4)
  );

  multicycle_mem #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(10), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .enable(en1), .wr(wr1), .addr(addr1), .data_in(din1),
    .data_out(dout1), .data_valid(dv1), .ready(rdy1)
  );

  typedef struct {
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t q4[$];
  exp_t q1[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Issue one request; returns at the negedge after the accepting edge.
  task automatic req(input bit sel, input logic w, input logic [15:0] a,
                     input logic [15:0] d, input logic [15:0] exp, output int acc);
    int n;
    int lat;
    exp_t e;
    n   = 0;
    lat = sel ? 1 : 4;
    while (!(sel ? rdy1 : rdy4) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("req_ready_timeout", 32'(n), 32'd0);
    if (sel) begin en1 = 1'b1; wr1 = w; addr1 = a; din1 = d; end
    else     begin en4 = 1'b1; wr4 = w; addr4 = a; din4 = d; end
    acc = cyc + 1;
    if (!w) begin
      e.data = exp;
      e.cyc  = acc + lat;
      if (sel) q1.push_back(e); else q4.push_back(e);
    end
    @(negedge clk);
    check("req_accepted_ready_low", {31'd0, sel ? rdy1 : rdy4}, 32'd0);
    if (sel) en1 = 1'b0; else en4 = 1'b0;
  endtask

  // Count cycles with ready low, starting from the current negedge.
  task automatic wait_idle(input bit sel, output int n);
    n = 0;
    while (!(sel ? rdy1 : rdy4) && n < 50) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Monitor: every data_valid pulse must match the head of its queue.
  logic dv4_prev = 1'b0, dv1_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (dv4) begin
      if (q4.size() == 0) check("dv4_unexpected", 32'd1, 32'd0);
      else begin
        e = q4.pop_front();
        check("rd4_data", {16'd0, dout4}, {16'd0, e.data});
        check("rd4_cycle", 32'(cyc), 32'(e.cyc));
      end
      if (dv4_prev) check("dv4_single_pulse", 32'd1, 32'd0);
    end
    if (dv1) begin
      if (q1.size() == 0) check("dv1_unexpected", 32'd1, 32'd0);
      else begin
        e = q1.pop_front();
        check("rd1_data", {16'd0, dout1}, {16'd0, e.data});
        check("rd1_cycle", 32'(cyc), 32'(e.cyc));
      end
      if (dv1_prev) check("dv1_single_pulse", 32'd1, 32'd0);
    end
    dv4_prev = dv4;
    dv1_prev = dv1;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int acc_a, acc_b, n;

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_ready", {31'd0, rdy4}, 32'd1);
    check("rst_data_valid", {31'd0, dv4}, 32'd0);
    check("rst_data_out", {16'd0, dout4}, 32'd0);

    // 1: preload mem[0]=0x1234, read it back, ready low for 4 cycles
    req(0, 1'b1, 16'h0000, 16'h1234, 16'h0, acc_a);
    wait_idle(0, n);
    req(0, 1'b0, 16'h0000, 16'h0, 16'h1234, acc_a);
    wait_idle(0, n);
    check("t1_ready_low_cycles", 32'(n), 32'd4);

    // 2: write leaves data_out unchanged, read-after-write returns new data
    req(0, 1'b1, 16'h0010, 16'hBEEF, 16'h0, acc_a);
    wait_idle(0, n);
    check("t2_wr_ready_low_cycles", 32'(n), 32'd4);
    check("t2_dout_unchanged", {16'd0, dout4}, 32'h1234);
    req(0, 1'b0, 16'h0010, 16'h0, 16'hBEEF, acc_a);
    wait_idle(0, n);

    // 3: back-to-back reads with zero bubble
    req(0, 1'b1, 16'h0002, 16'hAAAA, 16'h0, acc_a);
    req(0, 1'b1, 16'h0004, 16'h5555, 16'h0, acc_a);
    req(0, 1'b0, 16'h0002, 16'h0, 16'hAAAA, acc_a);
    req(0, 1'b0, 16'h0004, 16'h0, 16'h5555, acc_b);
    check("t3_zero_bubble_accept", 32'(acc_b - acc_a), 32'd5);
    wait_idle(0, n);

    // 4: aliasing - 0x0003 and 0x0802 map to word 1
    req(0, 1'b1, 16'h0003, 16'h0F0F, 16'h0, acc_a);
    req(0, 1'b0, 16'h0802, 16'h0, 16'h0F0F, acc_a);
    wait_idle(0, n);

    // Idle with enable low: nothing happens (monitor flags stray pulses)
    repeat (4) @(negedge clk);
    check("idle_ready", {31'd0, rdy4}, 32'd1);

    // 5: reset aborts an in-flight write
    req(0, 1'b1, 16'h0020, 16'h1111, 16'h0, acc_a);
    wait_idle(0, n);
    req(0, 1'b1, 16'h0020, 16'h7777, 16'h0, acc_a);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_ready_after_rst", {31'd0, rdy4}, 32'd1);
    check("t5_dv_after_rst", {31'd0, dv4}, 32'd0);
    // reset wins over a simultaneous request
    en4 = 1'b1; wr4 = 1'b0; addr4 = 16'h0020;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    en4 = 1'b0;
    @(negedge clk);
    check("t5_rst_beats_enable", {31'd0, rdy4}, 32'd1);
    req(0, 1'b0, 16'h0020, 16'h0, 16'h1111, acc_a);
    wait_idle(0, n);

    // 6: LATENCY=1 instance, addr change while busy is ignored
    req(1, 1'b1, 16'h0100, 16'hCAFE, 16'h0, acc_a);
    wait_idle(1, n);
    req(1, 1'b1, 16'h0200, 16'h1357, 16'h0, acc_a);
    wait_idle(1, n);
    req(1, 1'b0, 16'h0100, 16'h0, 16'hCAFE, acc_a);
    addr1 = 16'h0200;
    wait_idle(1, n);
    check("t6_ready_low_cycles", 32'(n), 32'd1);
    req(1, 1'b0, 16'h0200, 16'h0, 16'h1357, acc_a);
    wait_idle(1, n);

    repeat (8) @(negedge clk);
    check("q4_drained", 32'(q4.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
